// File: rtl/btn_pkg.sv
// Shared constants for the front-panel button conditioner: channel indices,
// default timing, and a counter-width helper.
package btn_pkg;

    // Channel assignment on the d/level/press/release buses
    localparam int BTN_SET    = 0;
    localparam int BTN_HOUR   = 1;
    localparam int BTN_MIN    = 2;
    localparam int BTN_ALARM  = 3;
    localparam int BTN_SNOOZE = 4;
    localparam int BTN_COUNT  = 5;

    // Default timing, in clk cycles (sync) or ce-qualified cycles (others)
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_HOLD_CYCLES     = 500;
    localparam int DEF_REPEAT_CYCLES   = 100;

    // Bits needed to count 0..n-1; never less than one bit
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: N-flop synchroniser, ce-qualified debounce counter,
// registered level and one-cycle press/release pulses.
// Optional auto-repeat of press while held: define BTN_AUTO_REPEAT_EN.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ce_i,
    input  logic d_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Parameter sanity, caught at elaboration
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("debounce_channel: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   sync_w;
    logic                   toggle_w;
    logic                   rise_w, fall_w;
    logic                   rep_fire_w;

    assign sync_w = sync_q[SYNC_STAGES-1];

    // Debounce: count ce cycles of disagreement; any agreement clears the run
    always_comb begin
        cnt_d    = cnt_q;
        toggle_w = 1'b0;
        if (sync_w == level_q) begin
            cnt_d = '0;
        end else if (ce_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d    = '0;
                toggle_w = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_d = level_q ^ toggle_w;
    assign rise_w  = toggle_w & ~level_q;
    assign fall_w  = toggle_w & level_q;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = cnt_width(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              repeating_q, repeating_d;

    // Hold timer: first interval is HOLD_CYCLES, later ones REPEAT_CYCLES;
    // a falling level in the same cycle suppresses the repeat
    always_comb begin
        hold_d      = hold_q;
        repeating_d = repeating_q;
        rep_fire_w  = 1'b0;
        if (!level_q) begin
            hold_d      = '0;
            repeating_d = 1'b0;
        end else if (ce_i) begin
            if (hold_q == (repeating_q ? REP_LAST : HOLD_LAST)) begin
                hold_d      = '0;
                repeating_d = 1'b1;
                rep_fire_w  = ~fall_w;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    // Hold timer state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q      <= '0;
            repeating_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            repeating_q <= repeating_d;
        end
    end
`else
    assign rep_fire_w = 1'b0;
`endif

    // rise needs level_q=0 and a repeat needs level_q=1, so they never overlap
    assign press_d   = rise_w | rep_fire_w;
    assign release_d = fall_w;

    // Synchroniser shifts every clk; debounce state and pulses are registered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], d_i};
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel front-panel input conditioner (SET, HOUR, MIN, ALARM_ON,
// SNOOZE by default). Each channel is an independent debounce_channel.
// Optional auto-repeat of press while held: define BTN_AUTO_REPEAT_EN.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int CHANNELS        = BTN_COUNT,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ce_i,
    input  logic [CHANNELS-1:0] d_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o
);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_chan (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .ce_i     (ce_i),
            .d_i      (d_i[ch]),
            .level_o  (level_o[ch]),
            .press_o  (press_o[ch]),
            .release_o(release_o[ch])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random stimulus,
// compared every cycle against a behavioural model of the channel rules.
module tb_button_conditioner;

    localparam int CH   = 5;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int REP  = 3;
    localparam int W    = 3 * CH;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic [CH-1:0] d;
    logic [CH-1:0] level, press, rel;

    always #5 clk = ~clk;

    button_conditioner #(
        .CHANNELS       (CH),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .ce_i     (ce),
        .d_i      (d),
        .level_o  (level),
        .press_o  (press),
        .release_o(rel)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // sync seen at an edge is the d sampled SYNC edges earlier; level flips
    // once DEB ce-edges of disagreement accumulate with no agreeing edge.
    logic [CH-1:0] hist[$];
    logic [CH-1:0] m_level, m_press, m_rel;
    int            run[CH];
    int            held[CH];
    logic [W-1:0]  exp_q[$];

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back('0);
        m_level = '0;
        m_press = '0;
        m_rel   = '0;
        for (int c = 0; c < CH; c++) begin
            run[c]  = 0;
            held[c] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_edge(input logic [CH-1:0] dv, input logic cev);
        logic [CH-1:0] s;
        logic          lv;
        s = hist.pop_front();
        hist.push_back(dv);
        m_press = '0;
        m_rel   = '0;
        for (int c = 0; c < CH; c++) begin
            lv = m_level[c];
            if (s[c] == lv) begin
                run[c] = 0;
            end else if (cev) begin
                run[c]++;
                if (run[c] == DEB) begin
                    run[c]     = 0;
                    m_level[c] = ~lv;
                    if (lv) m_rel[c] = 1'b1;
                    else    m_press[c] = 1'b1;
                end
            end
`ifdef BTN_AUTO_REPEAT_EN
            // ce-cycles counted since the level went high
            if (!lv) begin
                held[c] = 0;
            end else if (cev) begin
                held[c]++;
                if (!m_rel[c] && (held[c] == HOLD || (held[c] > HOLD && (held[c] - HOLD) % REP == 0)))
                    m_press[c] = 1'b1;
            end
`endif
        end
        exp_q.push_back({m_level, m_press, m_rel});
    endtask

    // ---------------- driver ----------------
    task automatic step(input string ph, input logic [CH-1:0] dv, input logic cev);
        logic [W-1:0] e;
        d  = dv;
        ce = cev;
        @(posedge clk);
        model_edge(dv, cev);
        #1;
        e = exp_q.pop_front();
        check({ph, ".level"},   32'(level), 32'(e[3*CH-1:2*CH]));
        check({ph, ".press"},   32'(press), 32'(e[2*CH-1:CH]));
        check({ph, ".release"}, 32'(rel),   32'(e[CH-1:0]));
        check({ph, ".excl"},    32'(press & rel), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [CH-1:0] dv;
    int            cnt_a, cnt_b;
    int            prob;

    initial begin
        rst = 1'b1;
        d   = '0;
        ce  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init.level", 32'(level), 32'd0);
        check("init.press", 32'(press), 32'd0);
        check("init.release", 32'(rel), 32'd0);
        rst = 1'b0;

        // clean press on channel 0
        cnt_a = 0;
        for (int i = 0; i < 3; i++) step("idle", 5'b00000, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step("clean", 5'b00001, 1'b1);
            if (i == 4) check("clean.before", 32'(level[0]), 32'd0);
            if (i == 5) check("clean.after", 32'(level[0]), 32'd1);
            cnt_a += int'(press[0]);
        end
        check("clean.press_count", 32'(cnt_a), 32'd1);

        // bounce on channel 1: high for 2 clks, low for 2 clks
        cnt_a = 0;
        for (int i = 0; i < 30; i++) begin
            dv    = 5'b00001;
            dv[1] = (i < 20) && ((i / 2) % 2 == 0);
            step("bounce", dv, 1'b1);
            cnt_a += int'(level[1]) + int'(press[1]) + int'(rel[1]);
        end
        check("bounce.activity", 32'(cnt_a), 32'd0);

        // ce gating on channel 2: one ce in three, then ce held low
        for (int i = 0; i < 24; i++) step("ce_gate", 5'b00101, (i % 3) == 0);
        check("ce_gate.rise", 32'(level[2]), 32'd1);
        for (int i = 0; i < 15; i++) step("ce_off", 5'b00001, 1'b0);
        check("ce_off.hold", 32'(level[2]), 32'd1);
        for (int i = 0; i < 10; i++) step("ce_on", 5'b00001, 1'b1);

        // simultaneous fall on channels 3 and 4
        for (int i = 0; i < 10; i++) step("simul_up", 5'b11001, 1'b1);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 10; i++) begin
            step("simul_dn", 5'b00001, 1'b1);
            cnt_a += int'(rel[3] & rel[4]);
            cnt_b += int'(rel[3] ^ rel[4]);
        end
        check("simul.both", 32'(cnt_a), 32'd1);
        check("simul.split", 32'(cnt_b), 32'd0);

        // hold channel 1; release timed so the fall lands on a repeat slot
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 45; i++) begin
            step("hold", (i < 32) ? 5'b00011 : 5'b00001, 1'b1);
            cnt_a += int'(press[1]);
            cnt_b += int'(rel[1]);
        end
`ifdef BTN_AUTO_REPEAT_EN
        check("hold.press_count", 32'(cnt_a), 32'd9);
`else
        check("hold.press_count", 32'(cnt_a), 32'd1);
`endif
        check("hold.release_count", 32'(cnt_b), 32'd1);

        // asynchronous reset mid-cycle with all inputs high
        d = 5'b11111;
        #3;
        rst = 1'b1;
        #1;
        check("rst.level", 32'(level), 32'd0);
        check("rst.press", 32'(press), 32'd0);
        check("rst.release", 32'(rel), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= 8; i++) begin
            step("post_rst", 5'b11111, 1'b1);
            if (i == 5) check("post_rst.edge5", 32'(level), 32'd0);
            if (i == 6) check("post_rst.edge6", 32'(level), 32'h1f);
        end

        // random stimulus; slow-toggle stretches exercise long holds
        dv = 5'b11111;
        for (int i = 0; i < 4000; i++) begin
            prob = ((i / 500) % 2 == 0) ? 6 : 60;
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, prob - 1) == 0) dv[c] = ~dv[c];
            step("rand", dv, $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
